// File: rtl/operand_fetch_pkg.sv
// Shared widths, constants and forwarding-source encoding for the decode-stage
// operand fetch block.
package operand_fetch_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;
    localparam int NUM_REGS    = 1 << REG_ADDR_W;

    localparam logic [WORD_WIDTH-1:0]  ZERO_WORD     = '0;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // Where a source operand's value comes from this cycle.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_EX,
        SRC_MEM,
        SRC_WB,
        SRC_RF
    } src_sel_e;

    // Forwarding priority: r0 is hard zero, then the youngest producer wins.
    function automatic src_sel_e pick_src(input logic nz, input logic ex_hit,
                                          input logic mem_hit, input logic wb_hit);
        if (!nz)          return SRC_ZERO;
        else if (ex_hit)  return SRC_EX;
        else if (mem_hit) return SRC_MEM;
        else if (wb_hit)  return SRC_WB;
        else              return SRC_RF;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// ID/EX/MEM/WB side-band bus into the operand fetch block, and its
// registered operand output toward EX.
interface operand_fetch_if #(
    parameter int W  = 32,
    parameter int AW = 5
);
    // decoded instruction
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    // pending producers
    logic          ex_wen;
    logic [AW-1:0] ex_waddr;
    logic [W-1:0]  ex_wdata;
    logic          ex_is_load;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic          wb_wen;
    logic [AW-1:0] wb_waddr;
    logic [W-1:0]  wb_wdata;
    // pipeline control
    logic          flush;
    logic          ex_ready;
    // outputs
    logic          stall;
    logic          op_valid;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [15:0]   stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_wen, ex_waddr, ex_wdata, ex_is_load,
        output mem_wen, mem_waddr, mem_wdata,
        output wb_wen, wb_waddr, wb_wdata,
        output flush, ex_ready,
        input  stall, op_valid, op_a, op_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_wen, ex_waddr, ex_wdata, ex_is_load,
        input  mem_wen, mem_waddr, mem_wdata,
        input  wb_wen, wb_waddr, wb_wdata,
        input  flush, ex_ready,
        output stall, op_valid, op_a, op_b, stall_cnt
    );

endinterface

// File: rtl/operand_fetch_regfile_2r1w.sv
// 32-entry general register file: two async read ports, one write port.
// r0 ignores writes and always reads zero.
module regfile_2r1w
    import operand_fetch_pkg::*;
#(
    parameter int W  = WORD_WIDTH,
    parameter int AW = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr0_i,
    output logic [W-1:0]  rdata0_o,
    input  logic [AW-1:0] raddr1_i,
    output logic [W-1:0]  rdata1_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];

    // Array write; reset clears every entry, r0 writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = (raddr0_i == '0) ? '0 : mem_q[raddr0_i];
    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand reader: register file, EX/MEM/WB forwarding, load-use
// detection and the registered operand pair handed to EX.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int W  = WORD_WIDTH,
    parameter int AW = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_fetch_if.slave bus
);

    // Index 0 is rs (op_a), index 1 is rt (op_b).
    logic [1:0][AW-1:0] src;
    logic [1:0]         use_src;
    logic [1:0][W-1:0]  rf_rd;
    logic [1:0][W-1:0]  res;
    logic [1:0]         hazard;

    assign src[0]     = bus.id_rs;
    assign src[1]     = bus.id_rt;
    assign use_src[0] = bus.id_use_rs;
    assign use_src[1] = bus.id_use_rt;

    regfile_2r1w #(.W(W), .AW(AW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (bus.wb_wen),
        .waddr_i  (bus.wb_waddr),
        .wdata_i  (bus.wb_wdata),
        .raddr0_i (src[0]),
        .rdata0_o (rf_rd[0]),
        .raddr1_i (src[1]),
        .rdata1_o (rf_rd[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic     nz;
        logic     ex_match;
        logic     ex_hit;
        logic     mem_hit;
        logic     wb_hit;
        src_sel_e sel;

        assign nz       = (src[g] != '0);
        assign ex_match = bus.ex_wen && (bus.ex_waddr == src[g]);
        // A load in EX has no data yet, so it never forwards.
        assign ex_hit   = ex_match && !bus.ex_is_load;
        assign mem_hit  = bus.mem_wen && (bus.mem_waddr == src[g]);
        assign wb_hit   = bus.wb_wen  && (bus.wb_waddr  == src[g]);
        assign sel      = pick_src(nz, ex_hit, mem_hit, wb_hit);

        assign res[g] = (sel == SRC_EX)  ? bus.ex_wdata  :
                        (sel == SRC_MEM) ? bus.mem_wdata :
                        (sel == SRC_WB)  ? bus.wb_wdata  :
                        (sel == SRC_RF)  ? rf_rd[g]      : '0;

        assign hazard[g] = bus.id_valid && use_src[g] && nz &&
                           ex_match && bus.ex_is_load;
    end

    logic                   load_use;
    logic                   hold;
    logic                   op_valid_q, op_valid_d;
    logic [W-1:0]           op_a_q, op_a_d;
    logic [W-1:0]           op_b_q, op_b_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign load_use  = |hazard;
    assign hold      = op_valid_q && !bus.ex_ready;
    assign bus.stall = !bus.flush && (load_use || hold);

    // Next-state for the operand register and the load-use stall counter.
    always_comb begin
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        stall_cnt_d = stall_cnt_q;

        if (bus.flush) begin
            op_valid_d = 1'b0;
        end else if (hold) begin
            op_valid_d = op_valid_q;
        end else if (load_use) begin
            // Bubble; operand data is left as-is.
            op_valid_d = 1'b0;
        end else begin
            op_valid_d = bus.id_valid;
            op_a_d     = res[0];
            op_b_d     = res[1];
        end

        // Counts load-use hazard cycles; flush suppresses the count.
        if (load_use && !bus.flush && (stall_cnt_q != STALL_CNT_MAX))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Operand register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.op_valid  = op_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-stage operand reader for the MIPS32 pipeline and the receiving end of the writeback interface. It holds the 32-entry general register file, which the writeback stage writes. It reads two source operands per instruction, forwards results still in EX/MEM/WB, and detects load-use hazards. Registered operands are presented to the EX stage with a valid/ready handshake.

## Interface
- `W`, default `WORD_WIDTH` (32): data word width.
- `AW`, default `REG_ADDR_W` (5): register address width.

- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  decoded instruction present.
- `id_rs`, `id_rt`  in  AW  source register addresses.
- `id_use_rs`, `id_use_rt`  in  1  instruction actually reads that source.
- `ex_wen`, `ex_waddr`, `ex_wdata`, `ex_is_load`  in  1/AW/W/1  EX-stage pending write (data is the ALU result).
- `mem_wen`, `mem_waddr`, `mem_wdata`  in  1/AW/W  MEM-stage pending write (final value).
- `wb_wen`, `wb_waddr`, `wb_wdata`  in  1/AW/W  writeback write port (writeback `write_en`/`reg_write_addr`/`reg_write_data`).
- `flush`  in  1  squash the instruction being fetched and the output register.
- `ex_ready`  in  1  EX accepts `op_valid` this cycle.
- `stall`  out  1  combinational; the ID stage must hold its instruction.
- `op_valid`  out  1  registered operand pair valid.
- `op_a`, `op_b`  out  W  registered rs/rt operand values.
- `stall_cnt`  out  16  saturating count of load-use stall cycles.

## Operation
- Register file: 32×W; the async reset clears every entry to 0. Writes to address 0 are discarded; reads of address 0 always return 0, with forwarding suppressed.
- On `posedge clk` with `wb_wen`, the array entry `wb_waddr` is written with `wb_wdata`.
- Source resolution for rs and rt, each independent, in priority order:
  1. EX match: `ex_wen`, `ex_waddr`==src, src≠0, and not `ex_is_load`.
  2. MEM match.
  3. WB match (same-cycle write bypass).
  4. Array.
- Load-use hazard: `id_valid`, `ex_wen`, `ex_is_load`, src≠0, `ex_waddr`==src, and that source is used. This drives `stall`=1.
- Backpressure: `op_valid` and `!ex_ready` also drives `stall`=1, and the output register holds its value.
- Output register update, in priority order:
  - `flush`: `op_valid`←0.
  - Else if holding under backpressure: no change.
  - Else if load-use hazard: `op_valid`←0 (bubble); `op_a`/`op_b` are don't-care and kept.
  - Else: `op_valid`←`id_valid`, `op_a`/`op_b`←resolved values.
- `stall` is masked to 0 when `flush` is high.
- `stall_cnt` increments on each cycle with a load-use hazard (not backpressure or flush). It saturates at 0xFFFF and clears only on reset.

## Timing
- Reset values: `op_valid`=0, `op_a`=`op_b`=0, `stall_cnt`=0, all registers 0. `stall` is combinational and 0 while `id_valid`=0.
- Latency: operands are registered; they appear 1 cycle after the ID cycle in which they resolve without stall.
- Writeback write and a same-cycle read of the same register: the reader gets the new data via bypass. The array holds it from the next cycle.
- Load-use costs exactly 1 bubble. Next cycle the load sits in MEM and `mem_wdata` is forwarded.
- Simultaneous EX and MEM match on the same source: EX wins. Simultaneous `flush` and hazard: flush wins, and the counter does not increment.
- Reset asserted mid-stall: all state clears immediately, independent of `clk`.

## Structure
- Shared `defines.v` holds `WORD_WIDTH`, `REG_ADDR_W`, and `ZERO_WORD`. Add `STALL_CNT_W` (16).
- Natural sub-module: `regfile_2r1w`, holding the array, reset clear, and r0 masking. Forwarding, hazard, and output register logic live in `operand_fetch`.

## Test plan
- Reset, then read r5/r6 with no writes → `op_a`=`op_b`=0 and `op_valid`=1 one cycle later.
- WB writes r3=0x1234 in the same cycle ID reads rs=r3 → `op_a`=0x1234. A later read with no WB activity also gives 0x1234.
- EX (r4=0xAAAA) and MEM (r4=0x5555) both pending, rs=r4 → `op_a`=0xAAAA. A write to r0 with 0xFFFF, then reading r0 → 0.
- EX load to r7 while ID uses rt=r7 → `stall`=1 for 1 cycle and a bubble (`op_valid`=0). Next cycle, MEM forwards 0xBEEF → `op_b`=0xBEEF and `stall_cnt`=1.
- Same load to r7 but the instruction does not use r7 (`id_use_rt`=0) → no stall.
- `ex_ready`=0 for 3 cycles → outputs held and `stall`=1. Then `flush` → `op_valid`=0 next cycle and `stall_cnt` unchanged.
